// File: rtl/fir_mac_engine_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR MAC engine.
package fir_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_OUT
    } fir_state_t;

    localparam int unsigned FIR_NTAPS = 64;
    localparam int unsigned FIR_DW    = 16;
    localparam int unsigned FIR_CW    = 16;
    localparam int unsigned FIR_OW    = 16;
    localparam int unsigned FIR_FRAC  = 15;

    // Enough headroom that NTAPS full-scale products can never overflow.
    function automatic int unsigned fir_acc_width(input int unsigned dw,
                                                  input int unsigned cw,
                                                  input int unsigned ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_mac_engine_round_sat.sv
// Round-half-up, shift by FRAC and reduce to OW bits.
// FIR_SAT_EN selects clamping with ovf; otherwise two's-complement wrap.
module fir_round_sat #(
    parameter int unsigned ACCW = 38,
    parameter int unsigned FRAC = 15,
    parameter int unsigned OW   = 16
) (
    input  logic signed [ACCW-1:0] acc,
    output logic signed [OW-1:0]   y,
    output logic                   ovf
);

    localparam logic signed [ACCW:0] HALF = (ACCW+1)'(1) << (FRAC-1);

    // One guard bit so adding the rounding constant cannot wrap.
    logic signed [ACCW:0] sum;
    logic signed [ACCW:0] rnd;

    assign sum = {acc[ACCW-1], acc} + HALF;
    assign rnd = sum >>> FRAC;

`ifdef FIR_SAT_EN
    localparam logic signed [ACCW:0] YMAX = {{(ACCW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACCW:0] YMIN = ~YMAX;

    always_comb begin
        y   = rnd[OW-1:0];
        ovf = 1'b0;
        if (rnd > YMAX) begin
            y   = YMAX[OW-1:0];
            ovf = 1'b1;
        end else if (rnd < YMIN) begin
            y   = YMIN[OW-1:0];
            ovf = 1'b1;
        end
    end
`else
    logic unused_hi;

    assign y         = rnd[OW-1:0];
    assign ovf       = 1'b0;
    assign unused_hi = ^rnd[ACCW:OW];
`endif

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR: serial coefficient load, one shared multiplier,
// NTAPS+3 cycles per sample. Output saturation is enabled by FIR_SAT_EN.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = FIR_NTAPS,
    parameter int unsigned DW    = FIR_DW,
    parameter int unsigned CW    = FIR_CW,
    parameter int unsigned OW    = FIR_OW,
    parameter int unsigned FRAC  = FIR_FRAC,
    parameter int unsigned ACCW  = fir_acc_width(DW, CW, NTAPS)
) (
    input  logic                 clk,
    input  logic                 ALU_restn,
    input  logic                 coef_start,
    input  logic                 coef_valid,
    input  logic signed [CW-1:0] coef_in,
    output logic                 coef_ready,
    input  logic                 x_valid,
    input  logic signed [DW-1:0] x_in,
    output logic                 x_ready,
    output logic                 y_valid,
    output logic signed [OW-1:0] y,
    output logic                 ovf
);

    localparam int unsigned KW = $clog2(NTAPS);
    localparam int unsigned PW = DW + CW;

    fir_state_t state, state_nx;

    logic [KW-1:0]          cidx;
    logic [KW-1:0]          k;
    logic signed [CW-1:0]   b [NTAPS];
    logic signed [DW-1:0]   d [NTAPS];
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic signed [OW-1:0]   y_r;
    logic                   ovf_r;
    logic                   last_coef;
    logic                   last_tap;

    assign last_coef  = (cidx == KW'(NTAPS-1));
    assign last_tap   = (k == KW'(NTAPS-1));
    assign coef_ready = (state == S_LOAD);
    assign x_ready    = (state == S_IDLE);

    always_ff @(posedge clk or negedge ALU_restn) begin
        if (!ALU_restn) state <= S_LOAD;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  if (coef_valid && last_coef) state_nx = S_IDLE;
            S_IDLE:  if (coef_start)              state_nx = S_LOAD;
                     else if (x_valid)            state_nx = S_MAC;
            S_MAC:   if (last_tap)                state_nx = S_DRAIN;
            S_DRAIN:                              state_nx = S_OUT;
            S_OUT:                                state_nx = S_IDLE;
            default:                              state_nx = S_LOAD;
        endcase
    end

    // The product is one cycle behind the tap index; DRAIN folds in the last one.
    always_ff @(posedge clk or negedge ALU_restn) begin
        if (!ALU_restn) begin
            cidx    <= '0;
            k       <= '0;
            b       <= '{default: '0};
            d       <= '{default: '0};
            prod    <= '0;
            acc     <= '0;
            y       <= '0;
            ovf     <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (coef_valid) begin
                        b[cidx] <= coef_in;
                        cidx    <= last_coef ? '0 : cidx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!coef_start && x_valid) begin
                        d[0] <= x_in;
                        for (int unsigned i = 1; i < NTAPS; i++) d[i] <= d[i-1];
                        acc  <= '0;
                        prod <= '0;
                        k    <= '0;
                    end
                end
                S_MAC: begin
                    prod <= PW'(d[k]) * PW'(b[k]);
                    acc  <= acc + ACCW'(prod);
                    k    <= last_tap ? '0 : k + 1'b1;
                end
                S_DRAIN: begin
                    acc <= acc + ACCW'(prod);
                end
                S_OUT: begin
                    y       <= y_r;
                    ovf     <= ovf_r;
                    y_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_round_sat #(
        .ACCW (ACCW),
        .FRAC (FRAC),
        .OW   (OW)
    ) u_round_sat (
        .acc (acc),
        .y   (y_r),
        .ovf (ovf_r)
    );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed self-checking bench for fir_mac_engine (default parameters).
module tb_fir_mac_engine;

    localparam int NT = 64;

    typedef struct {
        logic signed [15:0] x;
        int                 y;
        int                 ov;
    } vec_t;

    logic               clk = 1'b0;
    logic               ALU_restn = 1'b1;
    logic               coef_start = 1'b0;
    logic               coef_valid = 1'b0;
    logic signed [15:0] coef_in = '0;
    logic               coef_ready;
    logic               x_valid = 1'b0;
    logic signed [15:0] x_in = '0;
    logic               x_ready;
    logic               y_valid;
    logic signed [15:0] y;
    logic               ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic signed [15:0] cbuf [NT];

    bit lat_mode = 1'b0;
    int n_acc = 0;
    int n_y = 0;
    int acc_edge [16];
    int acc_x [16];
    int y_edge [16];
    int y_val [16];

    fir_mac_engine u_dut (
        .clk        (clk),
        .ALU_restn  (ALU_restn),
        .coef_start (coef_start),
        .coef_valid (coef_valid),
        .coef_in    (coef_in),
        .coef_ready (coef_ready),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .x_ready    (x_ready),
        .y_valid    (y_valid),
        .y          (y),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Records accepts (taken at the next edge) and result strobes (from the last edge).
    always @(negedge clk) begin
        if (lat_mode) begin
            if (x_valid && x_ready && n_acc < 16) begin
                acc_edge[n_acc] = cyc + 1;
                acc_x[n_acc]    = int'(x_in);
                n_acc++;
            end
            if (y_valid && n_y < 16) begin
                y_edge[n_y] = cyc;
                y_val[n_y]  = int'(y);
                n_y++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        coef_valid = 1'b0;
        coef_start = 1'b0;
        x_valid    = 1'b0;
        ALU_restn  = 1'b0;
        repeat (3) @(negedge clk);
        ALU_restn = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_coefs();
        int w = 0;
        while (!coef_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("coef_ready_before_load", int'(coef_ready), 1);
        for (int i = 0; i < NT; i++) begin
            if (i % 7 == 3) begin
                coef_valid = 1'b0;
                @(negedge clk);
            end
            coef_valid = 1'b1;
            coef_in    = cbuf[i];
            @(negedge clk);
        end
        coef_valid = 1'b0;
        check("x_ready_after_load", int'(x_ready), 1);
    endtask

    task automatic send_sample(input logic signed [15:0] xv, output int yg, output int og);
        int w = 0;
        yg = 0;
        og = 0;
        while (!x_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!x_ready) begin
            check("x_ready_timeout", int'(x_ready), 1);
            return;
        end
        x_valid = 1'b1;
        x_in    = xv;
        @(negedge clk);
        x_valid = 1'b0;
        w = 0;
        while (!y_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!y_valid) check("y_valid_timeout", int'(y_valid), 1);
        yg = int'(y);
        og = int'(ovf);
        @(negedge clk);
    endtask

    initial begin
        vec_t imp [NT];
        vec_t rnd [3];
        int   yg, og, ycount, prev;

        for (int n = 0; n < NT; n++) begin
            imp[n].x  = (n == 0) ? 16'h8000 : 16'h0000;
            imp[n].y  = -100 * n;
            imp[n].ov = 0;
        end
        rnd[0] = '{x: 16'sd1,  y: 1, ov: 0};
        rnd[1] = '{x: -16'sd1, y: 0, ov: 0};
        rnd[2] = '{x: 16'sd3,  y: 2, ov: 0};

        // Reset state
        do_reset();
        check("rst_y",          int'(y), 0);
        check("rst_y_valid",    int'(y_valid), 0);
        check("rst_ovf",        int'(ovf), 0);
        check("rst_coef_ready", int'(coef_ready), 1);
        check("rst_x_ready",    int'(x_ready), 0);

        // Impulse response
        for (int i = 0; i < NT; i++) cbuf[i] = 16'(100 * i);
        load_coefs();
        for (int n = 0; n < NT; n++) begin
            send_sample(imp[n].x, yg, og);
            check($sformatf("impulse_y[%0d]", n), yg, imp[n].y);
            check($sformatf("impulse_ovf[%0d]", n), og, imp[n].ov);
        end

        // Rounding, half toward +inf
        do_reset();
        for (int i = 0; i < NT; i++) cbuf[i] = '0;
        cbuf[0] = 16'sd16384;
        load_coefs();
        for (int n = 0; n < 3; n++) begin
            send_sample(rnd[n].x, yg, og);
            check($sformatf("round_y[%0d]", n), yg, rnd[n].y);
            check($sformatf("round_ovf[%0d]", n), og, rnd[n].ov);
        end

        // Saturation / wrap
        do_reset();
        for (int i = 0; i < NT; i++) cbuf[i] = 16'sd16384;
        load_coefs();
        for (int n = 0; n < NT; n++) begin
            send_sample(16'sd16384, yg, og);
            if (n == 0) begin
                check("sat_first_y",   yg, 8192);
                check("sat_first_ovf", og, 0);
            end
            if (n == NT - 1) begin
`ifdef FIR_SAT_EN
                check("sat_last_y",   yg, 32767);
                check("sat_last_ovf", og, 1);
`else
                check("sat_last_y",   yg, 0);
                check("sat_last_ovf", og, 0);
`endif
            end
        end

        // Back-to-back handshake with x_valid held high
        do_reset();
        for (int i = 0; i < NT; i++) cbuf[i] = '0;
        cbuf[0] = 16'sd16384;
        cbuf[1] = 16'sd16384;
        load_coefs();
        n_acc = 0;
        n_y   = 0;
        lat_mode = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b1;
        x_in    = 16'(100 + cyc);
        repeat (4 * (NT + 3)) begin
            @(posedge clk);
            #1 x_in = 16'(100 + cyc);
        end
        x_valid = 1'b0;
        repeat (NT + 10) @(negedge clk);
        lat_mode = 1'b0;
        check("lat_accept_count", n_acc, 4);
        check("lat_result_count", n_y, n_acc);
        prev = 0;
        for (int i = 0; i < n_acc && i < n_y; i++) begin
            if (i > 0) check($sformatf("lat_spacing[%0d]", i), acc_edge[i] - acc_edge[i-1], NT + 3);
            check($sformatf("lat_latency[%0d]", i), y_edge[i] - acc_edge[i], NT + 2);
            check($sformatf("lat_y[%0d]", i), y_val[i], (acc_x[i] + prev + 1) / 2);
            prev = acc_x[i];
        end

        // coef_start wins over x_valid in IDLE
        coef_start = 1'b1;
        x_valid    = 1'b1;
        x_in       = 16'sd777;
        @(negedge clk);
        coef_start = 1'b0;
        x_valid    = 1'b0;
        check("reload_coef_ready", int'(coef_ready), 1);
        check("reload_x_ready",    int'(x_ready), 0);
        for (int i = 0; i < NT; i++) cbuf[i] = '0;
        cbuf[0] = 16'sd32767;
        load_coefs();
        send_sample(16'sd1234, yg, og);
        check("reload_y",   yg, 1234);
        check("reload_ovf", og, 0);

        // Reset in the middle of a MAC run
        x_valid = 1'b1;
        x_in    = 16'sd1000;
        @(posedge clk);
        #1 x_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2 ALU_restn = 1'b0;
        ycount = 0;
        repeat (3) begin
            @(negedge clk);
            if (y_valid) ycount++;
        end
        ALU_restn = 1'b1;
        repeat (NT + 10) begin
            @(negedge clk);
            if (y_valid) ycount++;
        end
        check("midrst_no_y_valid", ycount, 0);
        check("midrst_coef_ready", int'(coef_ready), 1);
        check("midrst_x_ready",    int'(x_ready), 0);
        check("midrst_y",          int'(y), 0);
        check("midrst_ovf",        int'(ovf), 0);
        for (int i = 0; i < NT; i++) cbuf[i] = '0;
        load_coefs();
        send_sample(16'sd5000, yg, og);
        check("midrst_zero_coef_y", yg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
